deal_controller: RTL and testbench
==================================

Name: deal_controller

Overview:
- Sequences the card RNG for the blackjack game: arbitrates card requests from the player and dealer FSMs, fetches a raw value from the RNG over a req/valid handshake, and maps it to a card.
- Tracks dealt cards in a 52-bit deck bitmap so no card is dealt twice within a round.
- Sits between the RNG and the game-flow logic; its outputs feed scoring and the HEX display path.

Parameters:
- DECK_SIZE, 52, number of distinct cards; card index range 0..DECK_SIZE-1.
- VAL_W, 6, width of RNG value and card index.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- new_round  in  1  one-cycle pulse; reshuffles the deck by clearing the bitmap.
- p_req  in  1  player card request; level, held until p_ack.
- d_req  in  1  dealer card request; level, held until d_ack.
- rng_req  out  1  request to the RNG; held high until rng_valid.
- rng_valid  in  1  RNG value valid; accepted only while rng_req=1.
- rng_value  in  VAL_W  raw random value, 0..63.
- p_ack  out  1  one-cycle pulse completing a player request.
- d_ack  out  1  one-cycle pulse completing a dealer request.
- card_valid  out  1  one-cycle pulse; card_* outputs are meaningful.
- card_owner  out  1  0 = player, 1 = dealer.
- card_idx  out  VAL_W  card index, 0..51.
- card_rank  out  4  rank 1..13 (1 = Ace, 11..13 = J/Q/K), equal to card_idx mod 13, plus 1.
- card_suit  out  2  suit, equal to card_idx / 13.
- cards_left  out  VAL_W  undealt cards remaining, 0..52.
- deck_empty  out  1  high when cards_left = 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE; bitmap all 0; cards_left = 52; rr_last = dealer, so the player wins the first tie.
  - All strobes, rng_req and card_* outputs = 0; deck_empty = 0.
- States: IDLE, FETCH, PROBE, DELIVER, EMPTY_ACK.
- IDLE:
  - If new_round = 1, clear the bitmap, set cards_left = 52, stay in IDLE.
  - Otherwise, if any request is pending, grant it. On a tie, grant round-robin: the requester other than rr_last wins.
  - Latch the owner and update rr_last.
  - If cards_left = 0, go to EMPTY_ACK; otherwise go to FETCH.
- FETCH:
  - rng_req = 1. It is registered, so it first asserts in the cycle after the grant.
  - When rng_valid = 1, capture idx = rng_value if rng_value < 52, else rng_value - 52 (range 0..11). Go to PROBE.
- PROBE (one index per cycle):
  - If bitmap[idx] = 0, go to DELIVER.
  - Otherwise idx = idx + 1, wrapping 51 -> 0, and stay in PROBE.
  - cards_left > 0 guarantees termination within 52 cycles.
- DELIVER (one cycle):
  - card_valid = 1; the owner's ack = 1; card_* driven from idx.
  - Set bitmap[idx]; decrement cards_left.
  - Go to IDLE. card_* outputs hold their last value until the next delivery.
- EMPTY_ACK (one cycle): the owner's ack = 1, card_valid = 0, no rng_req. Go to IDLE.
- Minimum latency: grant in cycle T, rng_req in T+1; if rng_valid is also in T+1, PROBE in T+2, card_valid/ack in T+3.
- Each probe collision adds one cycle.
- new_round in FETCH/PROBE/DELIVER:
  - Has priority: abort to IDLE, clear the bitmap, set cards_left = 52, drop rng_req.
  - No ack and no card_valid for the aborted request. A requester still holding req is re-served from IDLE.
  - new_round in the same cycle as a DELIVER suppresses that delivery; the bitmap ends cleared.
- A requester deasserting req before its ack does not cancel: the card is still delivered to the latched owner.
- rng_valid while rng_req = 0 is ignored.
- A new request cannot be granted in the same cycle as the previous ack; IDLE is always visited between requests.
- deck_empty is combinational from cards_left and is exposed for game logic.

Test Plan:
- Reset, then p_req=1 held, RNG returns 17 in the same cycle as rng_req -> card_valid and p_ack in cycle T+3; card_idx=17, rank=5, suit=1, owner=0; cards_left=51.
- Card 17 already dealt, d_req=1, RNG returns 17 -> PROBE advances to 18 after one extra cycle; d_ack with card_idx=18, owner=1.
- RNG returns 60 -> idx 8, rank=9, suit=0. Cards 51 and 0 dealt, RNG returns 51 -> wraps and delivers idx=1.
- p_req and d_req rise in the same cycle, both held -> first grant to player, second to dealer; two acks, never simultaneous.
- Deal all 52 cards with random RNG values -> every card_idx unique, deck_empty=1. A further p_req -> p_ack with card_valid=0 and no rng_req.
- new_round pulsed while rng_req=1 and rng_valid held low -> rng_req drops next cycle, no ack, cards_left=52; the held request is then served normally.

Source files
------------

// File: rtl/deal_controller_if.sv
`default_nettype none
// ============================================================================
// deal_controller_if : card-request, RNG handshake and card-output bundle
// Revision: 1.0
// ============================================================================
interface deal_controller_if #(
    parameter int VAL_W = 6
);
    logic             new_round;
    logic             p_req;
    logic             d_req;
    logic             rng_req;
    logic             rng_valid;
    logic [VAL_W-1:0] rng_value;
    logic             p_ack;
    logic             d_ack;
    logic             card_valid;
    logic             card_owner;
    logic [VAL_W-1:0] card_idx;
    logic [3:0]       card_rank;
    logic [1:0]       card_suit;
    logic [VAL_W-1:0] cards_left;
    logic             deck_empty;
    logic             busy;

    modport slave (
        input  new_round, p_req, d_req, rng_valid, rng_value,
        output rng_req, p_ack, d_ack, card_valid, card_owner, card_idx,
               card_rank, card_suit, cards_left, deck_empty, busy
    );

    modport master (
        output new_round, p_req, d_req, rng_valid, rng_value,
        input  rng_req, p_ack, d_ack, card_valid, card_owner, card_idx,
               card_rank, card_suit, cards_left, deck_empty, busy
    );
endinterface
`default_nettype wire

// File: rtl/deal_controller.sv
`default_nettype none
// ============================================================================
// deal_controller : arbitrates player/dealer card requests, draws from the RNG
//                   and deals each card at most once per round.
// Revision: 1.0
// ============================================================================
module deal_controller #(
    parameter int DECK_SIZE = 52,
    parameter int VAL_W     = 6
) (
    input  wire logic          CLOCK_50,
    input  wire logic          resetn,
    deal_controller_if.slave   bus
);
    localparam logic [VAL_W-1:0] DECK_CNT = VAL_W'(DECK_SIZE);
    localparam logic [VAL_W-1:0] LAST_IDX = VAL_W'(DECK_SIZE - 1);
    localparam logic [VAL_W-1:0] SUIT_LEN = VAL_W'(13);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        PROBE     = 3'd2,
        DELIVER   = 3'd3,
        EMPTY_ACK = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [DECK_SIZE-1:0]   bitmap;
    logic [VAL_W-1:0]       cards_left;
    logic [VAL_W-1:0]       idx;
    logic                   owner;
    logic                   rr_last;
    logic                   rng_req;
    logic [VAL_W-1:0]       held_idx;
    logic [3:0]             held_rank;
    logic [1:0]             held_suit;
    logic                   held_owner;

    logic                   any_req;
    logic                   grant_dealer;
    logic                   deliver;
    logic                   empty_ack;
    logic [3:0]             idx_rank;
    logic [1:0]             idx_suit;
    logic [VAL_W-1:0]       folded_value;

    assign any_req      = bus.p_req | bus.d_req;
    // On a tie the requester that was not served last wins.
    assign grant_dealer = bus.d_req & (~bus.p_req | ~rr_last);
    assign idx_rank     = 4'(idx % SUIT_LEN) + 4'd1;
    assign idx_suit     = 2'(idx / SUIT_LEN);
    assign folded_value = (bus.rng_value >= DECK_CNT) ? (bus.rng_value - DECK_CNT)
                                                      : bus.rng_value;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!bus.new_round && any_req) begin
                    next_state = (cards_left == '0) ? EMPTY_ACK : FETCH;
                end
            end
            FETCH: begin
                if (bus.new_round) begin
                    next_state = IDLE;
                end else if (rng_req && bus.rng_valid) begin
                    next_state = PROBE;
                end
            end
            PROBE: begin
                if (bus.new_round) begin
                    next_state = IDLE;
                end else if (!bitmap[idx]) begin
                    next_state = DELIVER;
                end
            end
            DELIVER:   next_state = IDLE;
            EMPTY_ACK: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        deliver   = 1'b0;
        empty_ack = 1'b0;
        if (state == DELIVER) begin
            deliver = ~bus.new_round;
        end
        if (state == EMPTY_ACK) begin
            empty_ack = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bitmap     <= '0;
            cards_left <= DECK_CNT;
            idx        <= '0;
            owner      <= 1'b0;
            rr_last    <= 1'b1;
            rng_req    <= 1'b0;
            held_idx   <= '0;
            held_rank  <= '0;
            held_suit  <= '0;
            held_owner <= 1'b0;
        end else begin
            rng_req <= (next_state == FETCH);
            unique case (state)
                IDLE: begin
                    if (!bus.new_round && any_req) begin
                        owner   <= grant_dealer;
                        rr_last <= grant_dealer;
                    end
                end
                FETCH: begin
                    if (rng_req && bus.rng_valid) begin
                        idx <= folded_value;
                    end
                end
                PROBE: begin
                    if (bitmap[idx]) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + VAL_W'(1);
                    end
                end
                DELIVER: begin
                    if (!bus.new_round) begin
                        bitmap[idx] <= 1'b1;
                        cards_left  <= cards_left - VAL_W'(1);
                        held_idx    <= idx;
                        held_rank   <= idx_rank;
                        held_suit   <= idx_suit;
                        held_owner  <= owner;
                    end
                end
                default: ;
            endcase
            // A reshuffle overrides whatever the current state did to the deck.
            if (bus.new_round) begin
                bitmap     <= '0;
                cards_left <= DECK_CNT;
            end
        end
    end

    assign bus.rng_req    = rng_req;
    assign bus.card_valid = deliver;
    assign bus.p_ack      = (deliver | empty_ack) & ~owner;
    assign bus.d_ack      = (deliver | empty_ack) & owner;
    assign bus.card_idx   = deliver ? idx      : held_idx;
    assign bus.card_rank  = deliver ? idx_rank : held_rank;
    assign bus.card_suit  = deliver ? idx_suit : held_suit;
    assign bus.card_owner = deliver ? owner    : held_owner;
    assign bus.cards_left = cards_left;
    assign bus.deck_empty = (cards_left == '0);
    assign bus.busy       = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_deal_controller.sv
`default_nettype none
// ============================================================================
// tb_deal_controller : randomized scoreboard bench against a deck-level model
// Revision: 1.0
// ============================================================================
module tb_deal_controller;
    localparam int VAL_W = 6;

    logic CLOCK_50 = 1'b0;
    logic resetn;

    deal_controller_if #(.VAL_W(VAL_W)) bus ();

    deal_controller #(.DECK_SIZE(52), .VAL_W(VAL_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit owner;
        bit valid;
        int idx;
        int left;
    } exp_t;

    exp_t exp_q[$];
    int   rng_q[$];
    bit   dealt[52];
    int   m_left;
    bit   m_rr;
    int   checks;
    int   passes;
    bit   rng_mute;
    int   rng_delay;
    bit   saw_rng;

    function automatic void check(string name, longint act, longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 52; i++) dealt[i] = 1'b0;
        m_left = 52;
    endfunction

    // A grant draws v from the RNG and deals the first undealt card at or
    // after v folded into the deck, wrapping around.
    function automatic void model_grant(bit who, int v);
        exp_t e;
        int   start;
        int   c;
        bit   found;
        e.owner = who;
        e.idx   = 0;
        m_rr    = who;
        if (m_left == 0) begin
            e.valid = 1'b0;
            e.left  = 0;
        end else begin
            start   = (v >= 52) ? v - 52 : v;
            e.valid = 1'b1;
            e.left  = m_left;
            found   = 1'b0;
            for (int k = 0; k < 52; k++) begin
                c = (start + k) % 52;
                if (!found && !dealt[c]) begin
                    e.idx = c;
                    found = 1'b1;
                end
            end
            dealt[e.idx] = 1'b1;
            m_left--;
            rng_q.push_back(v);
        end
        exp_q.push_back(e);
    endfunction

    // RNG responder; also throws stray rng_valid pulses while no request is up.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.rng_valid = 1'b0;
        bus.rng_value = '0;
        forever begin
            @(negedge CLOCK_50);
            bus.rng_valid = 1'b0;
            if (bus.rng_req === 1'b1 && !rng_mute) begin
                if (wait_cnt < rng_delay) begin
                    wait_cnt++;
                end else if (rng_q.size() > 0) begin
                    bus.rng_valid = 1'b1;
                    bus.rng_value = VAL_W'(rng_q.pop_front());
                    wait_cnt      = 0;
                end
            end else begin
                wait_cnt = 0;
                if (bus.rng_req === 1'b0 && $urandom_range(0, 3) == 0) begin
                    bus.rng_valid = 1'b1;
                    bus.rng_value = VAL_W'($urandom_range(0, 63));
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (resetn && (bus.p_ack || bus.d_ack || bus.card_valid)) begin
                check("ack_exclusive", bus.p_ack & bus.d_ack, 0);
                check("ack_with_card", bus.p_ack | bus.d_ack, 1);
                check("expected_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ack_owner", bus.d_ack, e.owner);
                    check("card_valid", bus.card_valid, e.valid);
                    check("cards_left_at_ack", bus.cards_left, e.left);
                    if (e.valid) begin
                        check("card_idx", bus.card_idx, e.idx);
                        check("card_rank", bus.card_rank, e.idx % 13 + 1);
                        check("card_suit", bus.card_suit, e.idx / 13);
                        check("card_owner", bus.card_owner, e.owner);
                    end
                end
            end
        end
    end

    task automatic run_req(input bit wp, input bit wd, output int lat);
        int n;
        lat = -1;
        n   = 0;
        @(negedge CLOCK_50);
        bus.p_req = wp;
        bus.d_req = wd;
        while ((bus.p_req || bus.d_req) && n < 400) begin
            @(negedge CLOCK_50);
            n++;
            if (bus.rng_req) saw_rng = 1'b1;
            if (bus.p_ack || bus.d_ack) begin
                if (lat < 0) lat = n;
                if (bus.p_ack) bus.p_req = 1'b0;
                if (bus.d_ack) bus.d_req = 1'b0;
            end
        end
        check("request_served_in_time", bus.p_req | bus.d_req, 0);
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic single(input bit who, input int v, output int lat);
        model_grant(who, v);
        run_req(!who, who, lat);
    endtask

    task automatic pulse_new_round();
        @(negedge CLOCK_50);
        bus.new_round = 1'b1;
        @(negedge CLOCK_50);
        bus.new_round = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        bit tie_first;
        checks        = 0;
        passes        = 0;
        rng_mute      = 1'b0;
        rng_delay     = 0;
        saw_rng       = 1'b0;
        m_rr          = 1'b1;
        model_clear();
        resetn        = 1'b0;
        bus.new_round = 1'b0;
        bus.p_req     = 1'b0;
        bus.d_req     = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_busy", bus.busy, 0);
        check("reset_rng_req", bus.rng_req, 0);
        check("reset_cards_left", bus.cards_left, 52);
        check("reset_deck_empty", bus.deck_empty, 0);
        check("reset_card_valid", bus.card_valid, 0);
        check("reset_acks", {bus.p_ack, bus.d_ack}, 0);
        check("reset_card_fields", {bus.card_idx, bus.card_rank, bus.card_suit, bus.card_owner}, 0);
        resetn = 1'b1;

        // Player draws 17 with an immediate RNG reply: ack three cycles after grant.
        single(1'b0, 17, lat);
        check("min_latency", lat, 3);
        @(negedge CLOCK_50);
        check("cards_left_after_first", bus.cards_left, 51);
        check("card_idx_holds", bus.card_idx, 17);
        check("card_valid_is_pulse", bus.card_valid, 0);

        // Collision on 17 probes to 18; 60 folds to 8; 51 and 0 taken wraps to 1.
        single(1'b1, 17, lat);
        check("collision_latency", lat, 4);
        single(1'b0, 60, lat);
        single(1'b1, 51, lat);
        single(1'b0, 0, lat);
        single(1'b1, 51, lat);

        // Simultaneous requests: round-robin order, one ack each.
        tie_first = ~m_rr;
        model_grant(tie_first, 5);
        model_grant(~tie_first, 6);
        run_req(1'b1, 1'b1, lat);

        // Reshuffle while the RNG stalls: request aborted, then re-served.
        model_clear();
        model_grant(1'b0, 33);
        rng_mute = 1'b1;
        @(negedge CLOCK_50);
        bus.p_req = 1'b1;
        n = 0;
        while (!bus.rng_req && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("rng_req_raised", bus.rng_req, 1);
        @(negedge CLOCK_50);
        bus.new_round = 1'b1;
        @(negedge CLOCK_50);
        bus.new_round = 1'b0;
        check("abort_drops_rng_req", bus.rng_req, 0);
        check("abort_refills_deck", bus.cards_left, 52);
        rng_mute = 1'b0;
        run_req(1'b1, 1'b0, lat);

        // Fresh deck dealt out completely with random owners and RNG values.
        pulse_new_round();
        for (int i = 0; i < 52; i++) begin
            rng_delay = $urandom_range(0, 3);
            single(1'($urandom_range(0, 1)), $urandom_range(0, 63), lat);
        end
        rng_delay = 0;
        @(negedge CLOCK_50);
        check("deck_empty_after_52", bus.deck_empty, 1);
        check("cards_left_after_52", bus.cards_left, 0);

        // Empty deck: ack without a card and without touching the RNG.
        saw_rng = 1'b0;
        single(1'b0, 0, lat);
        check("empty_no_rng_req", saw_rng, 0);

        repeat (3) @(negedge CLOCK_50);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
